rf_dump_streamer: RTL and testbench
===================================

Name: rf_dump_streamer

Overview:
- Debug readout engine that sits beside the CPU register file (xREG array) on a dedicated asynchronous read port.
- On a start pulse it walks a range of architectural registers and streams each {index, value} pair out over a valid/ready interface.
- This is the hardware-side reader of register state: it gives benches and debug hosts an in-band stream instead of hierarchical peeks into the register file.

Parameters:
- XLEN, 32, register data width
- NREG, 32, number of architectural registers (power of two)
- AW, 5, register index width, log2(NREG)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  synchronous reset, active-high
- i_start  in  1  one-cycle request to begin a dump; honoured only in IDLE
- i_first  in  AW  first register index of the range; sampled with i_start
- i_last  in  AW  last register index of the range, inclusive; sampled with i_start
- o_busy  out  1  high in every state except IDLE
- o_rf_addr  out  AW  read address to the register-file debug port
- i_rf_data  in  XLEN  combinational read data for o_rf_addr
- o_valid  out  1  output beat valid
- i_ready  in  1  consumer accepts the beat
- o_idx  out  AW  register index of the current beat
- o_data  out  XLEN  register value of the current beat
- o_done  out  1  one-cycle pulse when the dump completes
- o_count  out  AW+1  number of beats emitted by the most recent dump

Behaviour:
- Reset values: state=IDLE; o_busy, o_valid and o_done are 0; o_idx, o_data, o_rf_addr and o_count are 0.
- Reset mid-dump: the FSM returns to IDLE on that edge and o_valid drops. The partial beat is discarded and o_done does not pulse.
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - On i_start, latch ptr=i_first and end=i_last, clear the beat counter, and go to FETCH.
  - i_start outside IDLE is ignored.
- FETCH:
  - Drive o_rf_addr=ptr.
  - At the edge, register o_idx=ptr and o_data=(ptr==0 ? 0 : i_rf_data). x0 is always reported as 0.
  - Next state is SEND.
- SEND:
  - o_valid=1. o_idx and o_data stay stable until the handshake (o_valid && i_ready).
  - On handshake, the counter increments.
  - If ptr==end, go to DONE; otherwise ptr=ptr+1 modulo NREG and go to FETCH.
  - No handshake: stay in SEND indefinitely.
- DONE:
  - o_done=1 for exactly one cycle and o_count is updated.
  - Next state is IDLE; o_busy falls on that edge.
- Latency:
  - i_start at cycle 0 gives FETCH at cycle 1 and the first o_valid at cycle 2.
  - Peak throughput is one beat per 2 cycles when i_ready is held high.
- Range wraps: i_first > i_last walks upward through NREG-1 to 0, then on to i_last. Example: 30,31,0,1.
- i_first == i_last produces exactly one beat.
- The full range 0..NREG-1 produces NREG beats and o_count=NREG. o_count is AW+1 bits, so 32 does not overflow.
- i_ready while o_valid=0 has no effect.
- The register file may be written during a dump. Each beat carries the value read during its own FETCH cycle; there is no snapshot.
- o_rf_addr holds ptr in all states, so it is don't-care outside FETCH.

Optional Feature:
- Macro: RF_DUMP_SKIP_ZERO_EN
- Defined:
  - In FETCH, a read value of 0 (including x0) emits no beat.
  - If ptr==end, go to DONE; otherwise advance ptr and stay in FETCH.
  - o_count counts emitted beats only.
  - A range that is all zero gives o_done after the last FETCH with o_count=0 and no o_valid.
- Undefined: every register in the range is emitted, as described above.

Test Plan:
- Preload x1=5, x2=7, x3=12. Pulse i_start with first=1, last=3, i_ready=1.
  - Beats (1,5), (2,7), (3,12); o_valid first seen 2 cycles after start, one beat every 2 cycles.
  - o_done pulses once; o_count=3.
- Wrap range: first=30, last=1, x0 forced written 0xFFFFFFFF internally.
  - Index order 30,31,0,1; the idx-0 beat carries data 0; o_count=4.
- Backpressure: i_ready=0 for 5 cycles while o_valid=1.
  - o_idx and o_data stay stable, no advance; completes normally after i_ready rises.
- i_start pulsed again mid-dump: ignored; beat order and o_count unaffected.
- i_rst asserted during SEND: next cycle o_valid=0, o_busy=0, no o_done. A fresh start after reset runs correctly.
- With RF_DUMP_SKIP_ZERO_EN: range 0..31 with only x5=9 and x9=3 nonzero.
  - Exactly 2 beats, (5,9) then (9,3); o_count=2.
  - An all-zero range gives o_done with o_count=0.

Source files
------------

// File: rtl/rf_dump_streamer_if.sv
// Beat stream carrying {index, value} pairs from rf_dump_streamer to its consumer.
interface rf_dump_streamer_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            valid;
   logic            ready;
   logic [AW-1:0]   idx;
   logic [XLEN-1:0] data;

   modport master (output valid, output idx, output data, input ready);
   modport slave  (input valid, input idx, input data, output ready);
endinterface

// File: rtl/rf_dump_streamer.sv
// Walks a register-file index range and streams {index, value} beats out.
// Optional macro RF_DUMP_SKIP_ZERO_EN suppresses beats whose value reads as zero.
module rf_dump_streamer #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [AW-1:0]    i_first,
   input  logic [AW-1:0]    i_last,
   output logic             o_busy,
   output logic [AW-1:0]    o_rf_addr,
   input  logic [XLEN-1:0]  i_rf_data,
   rf_dump_streamer_if.master stream,
   output logic             o_done,
   output logic [AW:0]      o_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_r, state_s;
   logic [AW-1:0]   ptr_r, ptr_s;
   logic [AW-1:0]   end_r, end_s;
   logic [AW:0]     cnt_r, cnt_s;
   logic [AW-1:0]   idx_r, idx_s;
   logic [XLEN-1:0] data_r, data_s;
   logic            busy_r, valid_r, done_r;
   logic [AW:0]     count_r;
   logic [XLEN-1:0] rd_s;
   logic [AW-1:0]   ptr_inc_s;
   logic            last_s;

   assign rd_s      = (ptr_r == {AW{1'b0}}) ? {XLEN{1'b0}} : i_rf_data;
   assign ptr_inc_s = (ptr_r == AW'(NREG - 1)) ? {AW{1'b0}} : ptr_r + AW'(1);
   assign last_s    = (ptr_r == end_r);

   // Next-state and datapath decode.
   always_comb begin
      state_s = state_r;
      ptr_s   = ptr_r;
      end_s   = end_r;
      cnt_s   = cnt_r;
      idx_s   = idx_r;
      data_s  = data_r;
      case (state_r)
         IDLE: begin
            if (i_start) begin
               ptr_s   = i_first;
               end_s   = i_last;
               cnt_s   = {(AW+1){1'b0}};
               state_s = FETCH;
            end else begin
               state_s = IDLE;
            end
         end
         FETCH: begin
`ifdef RF_DUMP_SKIP_ZERO_EN
            if (rd_s == {XLEN{1'b0}}) begin
               if (last_s) begin
                  state_s = DONE;
               end else begin
                  ptr_s   = ptr_inc_s;
                  state_s = FETCH;
               end
            end else begin
               idx_s   = ptr_r;
               data_s  = rd_s;
               state_s = SEND;
            end
`else
            idx_s   = ptr_r;
            data_s  = rd_s;
            state_s = SEND;
`endif
         end
         SEND: begin
            if (valid_r && stream.ready) begin
               cnt_s = cnt_r + (AW+1)'(1);
               if (last_s) begin
                  state_s = DONE;
               end else begin
                  ptr_s   = ptr_inc_s;
                  state_s = FETCH;
               end
            end else begin
               state_s = SEND;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, datapath and registered output flags.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= IDLE;
         ptr_r   <= {AW{1'b0}};
         end_r   <= {AW{1'b0}};
         cnt_r   <= {(AW+1){1'b0}};
         idx_r   <= {AW{1'b0}};
         data_r  <= {XLEN{1'b0}};
         busy_r  <= 1'b0;
         valid_r <= 1'b0;
         done_r  <= 1'b0;
         count_r <= {(AW+1){1'b0}};
      end else begin
         state_r <= state_s;
         ptr_r   <= ptr_s;
         end_r   <= end_s;
         cnt_r   <= cnt_s;
         idx_r   <= idx_s;
         data_r  <= data_s;
         busy_r  <= (state_s != IDLE);
         valid_r <= (state_s == SEND);
         done_r  <= (state_s == DONE);
         // o_count becomes visible together with the o_done pulse.
         if (state_s == DONE) begin
            count_r <= cnt_s;
         end else begin
            count_r <= count_r;
         end
      end
   end

   assign o_busy       = busy_r;
   assign o_rf_addr    = ptr_r;
   assign o_done       = done_r;
   assign o_count      = count_r;
   assign stream.valid = valid_r;
   assign stream.idx   = idx_r;
   assign stream.data  = data_r;

endmodule

// File: tb/tb_rf_dump_streamer.sv
// Directed self-checking bench for rf_dump_streamer with a behavioural register file.
module tb_rf_dump_streamer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [4:0]  first, last;
   logic        busy;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;
   logic        done;
   logic [5:0]  count;
   logic [31:0] regs [0:31];

   int n_checks = 0;
   int n_errors = 0;

   logic [4:0]  b_idx  [0:63];
   logic [31:0] b_data [0:63];
   int          b_cyc  [0:63];
   int          nb, ndone, done_cyc;
   logic [5:0]  done_count;

   rf_dump_streamer_if #(.XLEN(32), .AW(5)) s_if ();

   rf_dump_streamer #(.XLEN(32), .NREG(32), .AW(5)) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_start   (start),
      .i_first   (first),
      .i_last    (last),
      .o_busy    (busy),
      .o_rf_addr (rf_addr),
      .i_rf_data (rf_data),
      .stream    (s_if),
      .o_done    (done),
      .o_count   (count)
   );

   always #5 clk = ~clk;
   assign rf_data = regs[rf_addr];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one dump; optionally stalls a given beat and re-pulses start mid-dump.
   task automatic dump(input logic [4:0] f, input logic [4:0] l,
                       input int stall_beat, input int stall_len, input int restart_cyc);
      int          stall_left;
      logic [4:0]  hold_idx;
      logic [31:0] hold_data;
      nb = 0; ndone = 0; done_cyc = 0; done_count = 6'd0;
      stall_left = stall_len;
      hold_idx = 5'd0; hold_data = 32'd0;
      @(negedge clk);
      first = f; last = l; start = 1'b1; s_if.ready = 1'b1;
      for (int cyc = 1; cyc <= 300 && ndone == 0; cyc++) begin
         @(negedge clk);
         start = (cyc == restart_cyc);
         if (cyc == restart_cyc) begin
            first = 5'd7; last = 5'd8;
         end
         if (s_if.valid && nb == stall_beat && stall_left > 0) begin
            s_if.ready = 1'b0;
            if (stall_left == stall_len) begin
               hold_idx = s_if.idx; hold_data = s_if.data;
            end else begin
               check("stall_idx", 64'(s_if.idx), 64'(hold_idx));
               check("stall_data", 64'(s_if.data), 64'(hold_data));
            end
            stall_left--;
         end else begin
            s_if.ready = 1'b1;
         end
         if (done) begin
            ndone++; done_cyc = cyc; done_count = count;
         end
         if (s_if.valid && s_if.ready && nb < 64) begin
            b_idx[nb] = s_if.idx; b_data[nb] = s_if.data; b_cyc[nb] = cyc;
            nb++;
         end
      end
      start = 1'b0;
      if (ndone == 0) check("timeout", 64'd0, 64'd1);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("idle_busy", 64'(busy), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regs[i] = 32'd0;
      regs[0] = 32'hFFFF_FFFF;
      regs[1] = 32'd5; regs[2] = 32'd7; regs[3] = 32'd12;
      regs[30] = 32'h30; regs[31] = 32'h31;
      rst = 1'b1; start = 1'b0; first = 5'd0; last = 5'd0; s_if.ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(s_if.valid), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_idx", 64'(s_if.idx), 64'd0);
      check("rst_data", 64'(s_if.data), 64'd0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_addr", 64'(rf_addr), 64'd0);
      rst = 1'b0;
      // i_ready with no valid beat must be harmless.
      s_if.ready = 1'b1;
      repeat (2) @(negedge clk);
      check("ready_idle_valid", 64'(s_if.valid), 64'd0);

      // Basic range 1..3 at full throughput.
      dump(5'd1, 5'd3, -1, 0, 0);
      check("t1_nb", 64'(nb), 64'd3);
      check("t1_b0", {27'd0, b_idx[0], b_data[0]}, {27'd0, 5'd1, 32'd5});
      check("t1_b1", {27'd0, b_idx[1], b_data[1]}, {27'd0, 5'd2, 32'd7});
      check("t1_b2", {27'd0, b_idx[2], b_data[2]}, {27'd0, 5'd3, 32'd12});
      check("t1_cyc0", 64'(b_cyc[0]), 64'd2);
      check("t1_cyc1", 64'(b_cyc[1]), 64'd4);
      check("t1_cyc2", 64'(b_cyc[2]), 64'd6);
      check("t1_done_cyc", 64'(done_cyc), 64'd7);
      check("t1_ndone", 64'(ndone), 64'd1);
      check("t1_count", 64'(done_count), 64'd3);

      // Backpressure on the second beat for 5 cycles.
      dump(5'd1, 5'd3, 1, 5, 0);
      check("t3_nb", 64'(nb), 64'd3);
      check("t3_b1", {27'd0, b_idx[1], b_data[1]}, {27'd0, 5'd2, 32'd7});
      check("t3_cyc1", 64'(b_cyc[1]), 64'd9);
      check("t3_cyc2", 64'(b_cyc[2]), 64'd11);
      check("t3_count", 64'(done_count), 64'd3);

      // Start re-pulsed mid-dump is ignored.
      dump(5'd1, 5'd3, -1, 0, 3);
      check("t4_nb", 64'(nb), 64'd3);
      check("t4_b1", 64'(b_idx[1]), 64'd2);
      check("t4_b2", 64'(b_idx[2]), 64'd3);
      check("t4_count", 64'(done_count), 64'd3);
      check("t4_ndone", 64'(ndone), 64'd1);

      // Reset while a beat is pending in SEND.
      @(negedge clk);
      first = 5'd1; last = 5'd3; start = 1'b1; s_if.ready = 1'b0;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      check("t5_valid_pre", 64'(s_if.valid), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("t5_valid", 64'(s_if.valid), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      check("t5_done", 64'(done), 64'd0);
      ndone = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("t5_no_done", 64'(ndone), 64'd0);
      dump(5'd2, 5'd2, -1, 0, 0);
      check("t5_single_nb", 64'(nb), 64'd1);
      check("t5_single_b", {27'd0, b_idx[0], b_data[0]}, {27'd0, 5'd2, 32'd7});
      check("t5_single_count", 64'(done_count), 64'd1);

`ifndef RF_DUMP_SKIP_ZERO_EN
      // Wrapping range 30..1 with x0 holding a nonzero value in the array.
      dump(5'd30, 5'd1, -1, 0, 0);
      check("t2_nb", 64'(nb), 64'd4);
      check("t2_b0", {27'd0, b_idx[0], b_data[0]}, {27'd0, 5'd30, 32'h30});
      check("t2_b1", {27'd0, b_idx[1], b_data[1]}, {27'd0, 5'd31, 32'h31});
      check("t2_b2", {27'd0, b_idx[2], b_data[2]}, {27'd0, 5'd0, 32'd0});
      check("t2_b3", {27'd0, b_idx[3], b_data[3]}, {27'd0, 5'd1, 32'd5});
      check("t2_count", 64'(done_count), 64'd4);

      // Full range produces NREG beats.
      dump(5'd0, 5'd31, -1, 0, 0);
      check("t6_nb", 64'(nb), 64'd32);
      check("t6_count", 64'(done_count), 64'd32);
      check("t6_last", {27'd0, b_idx[31], b_data[31]}, {27'd0, 5'd31, 32'h31});
`else
      for (int i = 1; i < 32; i++) regs[i] = 32'd0;
      regs[5] = 32'd9; regs[9] = 32'd3;
      dump(5'd0, 5'd31, -1, 0, 0);
      check("sz_nb", 64'(nb), 64'd2);
      check("sz_b0", {27'd0, b_idx[0], b_data[0]}, {27'd0, 5'd5, 32'd9});
      check("sz_b1", {27'd0, b_idx[1], b_data[1]}, {27'd0, 5'd9, 32'd3});
      check("sz_count", 64'(done_count), 64'd2);
      dump(5'd10, 5'd20, -1, 0, 0);
      check("sz_zero_nb", 64'(nb), 64'd0);
      check("sz_zero_done", 64'(ndone), 64'd1);
      check("sz_zero_count", 64'(done_count), 64'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
